// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stage indices for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   localparam int NSTG_DEF    = 5;
   localparam int STG_PC      = 0;
   localparam int STG_IF2ID   = 1;
   localparam int STG_ID2EXE  = 2;
   localparam int STG_EXE2MEM = 3;
   localparam int STG_MEM2WB  = 4;

endpackage

// File: rtl/pipe_ctrl_stall_dec.sv
// Priority decoder: the deepest stalling stage holds every register up to it
// and pushes a bubble into the register immediately behind it.
module pipe_ctrl_stall_dec
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTG = NSTG_DEF
) (
   input  logic            stallreq_id_i,
   input  logic            stallreq_exe_i,
   input  logic            stallreq_mem_i,
   output logic [NSTG-1:0] stall_o,
   output logic [NSTG-1:0] bubble_o
);

   // -1 means no register is held
   int deep;

   always_comb begin
      deep = -1;
      if (stallreq_mem_i)      deep = STG_EXE2MEM;
      else if (stallreq_exe_i) deep = STG_ID2EXE;
      else if (stallreq_id_i)  deep = STG_IF2ID;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NSTG; gi++) begin : g_stg
         assign stall_o[gi]  = (gi <= deep);
         assign bubble_o[gi] = (deep >= 0) && (gi == deep + 1);
      end
   endgenerate

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer with redirect deferral behind MEM bus waits and a stall counter.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTG      = NSTG_DEF,
   parameter int CNT_W     = 32,
   parameter int WDT_LIMIT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id_i,
   input  logic             stallreq_exe_i,
   input  logic             stallreq_mem_i,
   input  logic             flush_req_i,
   input  logic [31:0]      flush_pc_i,
   output logic [NSTG-1:0]  stall_o,
   output logic [NSTG-1:0]  flush_o,
   output logic             new_pc_valid_o,
   output logic [31:0]      new_pc_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic             wdt_timeout_o
);

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [NSTG-1:0]   dec_stall, dec_bubble;

   pipe_ctrl_stall_dec #(.NSTG(NSTG)) u_dec (
      .stallreq_id_i  (stallreq_id_i),
      .stallreq_exe_i (stallreq_exe_i),
      .stallreq_mem_i (stallreq_mem_i),
      .stall_o        (dec_stall),
      .bubble_o       (dec_bubble)
   );

   // A redirect waits in HOLD while MEM is mid-transaction; later requests are dropped.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      stall_o        = dec_stall;
      flush_o        = dec_bubble;
      new_pc_valid_o = 1'b0;
      case (state_q)
         RUN: begin
            if (flush_req_i) begin
               pc_d    = flush_pc_i;
               state_d = stallreq_mem_i ? HOLD : FLUSH;
            end
         end
         HOLD: begin
            if (!stallreq_mem_i) state_d = FLUSH;
         end
         FLUSH: begin
            stall_o        = '0;
            flush_o        = '1;
            new_pc_valid_o = 1'b1;
            state_d        = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign stall_cnt_d = stall_cnt_q + CNT_W'(stall_o[STG_PC]);
   assign new_pc_o    = pc_q;
   assign stall_cnt_o = stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef PIPE_CTRL_STALL_WDT_EN
   localparam int WDT_W = $clog2(WDT_LIMIT + 1);

   logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;
   logic             wdt_q, wdt_d;

   // Run length saturates at the limit so a long stall cannot wrap it back below.
   always_comb begin
      wdt_cnt_d = '0;
      if (stall_o[STG_PC]) begin
         wdt_cnt_d = (wdt_cnt_q == WDT_W'(WDT_LIMIT)) ? wdt_cnt_q : wdt_cnt_q + 1'b1;
      end
      wdt_d = wdt_q | (wdt_cnt_d == WDT_W'(WDT_LIMIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdt_cnt_q <= '0;
         wdt_q     <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_q     <= wdt_d;
      end
   end

   assign wdt_timeout_o = wdt_q;
`else
   // Limit only matters when the watchdog is built; keep it referenced.
   if (WDT_LIMIT < 1) begin : g_wdt_limit_invalid
   end
   assign wdt_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed checks of pipe_ctrl against a cycle-level reference model.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id_i, stallreq_exe_i, stallreq_mem_i;
   logic        flush_req_i;
   logic [31:0] flush_pc_i;
   logic [4:0]  stall_o, flush_o;
   logic        new_pc_valid_o;
   logic [31:0] new_pc_o;
   logic [3:0]  stall_cnt_o;
   logic        wdt_timeout_o;

   pipe_ctrl #(.NSTG(5), .CNT_W(4), .WDT_LIMIT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .stallreq_id_i  (stallreq_id_i),
      .stallreq_exe_i (stallreq_exe_i),
      .stallreq_mem_i (stallreq_mem_i),
      .flush_req_i    (flush_req_i),
      .flush_pc_i     (flush_pc_i),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .new_pc_valid_o (new_pc_valid_o),
      .new_pc_o       (new_pc_o),
      .stall_cnt_o    (stall_cnt_o),
      .wdt_timeout_o  (wdt_timeout_o)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: redirect pending/now, latched target, counters
   bit          m_flush_now, m_waiting, m_wdt;
   logic [31:0] m_target;
   int          m_cnt, m_run;

   logic [4:0]  exp_stall, exp_flush;
   logic        exp_valid, exp_wdt;
   logic [31:0] exp_pc;
   logic [3:0]  exp_cnt;

   task automatic model_reset();
      m_flush_now = 0; m_waiting = 0; m_wdt = 0;
      m_target = '0; m_cnt = 0; m_run = 0;
   endtask

   // Drive one cycle of inputs and work out what the outputs should be.
   task automatic apply(input bit id, input bit exe, input bit mem, input bit req,
                        input logic [31:0] pc);
      int held;
      stallreq_id_i = id; stallreq_exe_i = exe; stallreq_mem_i = mem;
      flush_req_i = req; flush_pc_i = pc;
      if (m_flush_now) begin
         exp_stall = 5'h00; exp_flush = 5'h1f; exp_valid = 1'b1;
      end else begin
         held = mem ? 4 : exe ? 3 : id ? 2 : 0;
         exp_stall = 5'((1 << held) - 1);
         exp_flush = (held == 0) ? 5'h00 : 5'(1 << held);
         exp_valid = 1'b0;
      end
      exp_pc  = m_target;
      exp_cnt = m_cnt[3:0];
      exp_wdt = m_wdt;
      #3;
   endtask

   task automatic tick();
      @(posedge clk);
      m_cnt = (m_cnt + int'(exp_stall[0])) % 16;
      m_run = exp_stall[0] ? m_run + 1 : 0;
`ifdef PIPE_CTRL_STALL_WDT_EN
      if (m_run >= 8) m_wdt = 1;
`endif
      if (m_flush_now) m_flush_now = 0;
      else if (m_waiting) begin
         if (!stallreq_mem_i) begin m_waiting = 0; m_flush_now = 1; end
      end else if (flush_req_i) begin
         m_target = flush_pc_i;
         if (stallreq_mem_i) m_waiting = 1; else m_flush_now = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      stallreq_id_i = 0; stallreq_exe_i = 0; stallreq_mem_i = 0;
      flush_req_i = 0; flush_pc_i = '0;
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      stallreq_id_i = 0; stallreq_exe_i = 0; stallreq_mem_i = 0;
      flush_req_i = 0; flush_pc_i = '0;
      rst = 1'b1;
      model_reset();
      #2;
      vectors++;
      if ({stall_o, flush_o, new_pc_valid_o, new_pc_o, stall_cnt_o, wdt_timeout_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got stall=%b flush=%b v=%b pc=%h cnt=%0d wdt=%b want all 0",
                  stall_o, flush_o, new_pc_valid_o, new_pc_o, stall_cnt_o, wdt_timeout_o);
      end
      @(posedge clk); #1 rst = 1'b0;
      // enter HOLD, then reset mid-cycle
      apply(0, 0, 1, 1, 32'h1234_5678); tick();
      apply(0, 0, 1, 0, 32'h0);
      vectors++;
      if (stall_o !== 5'b01111 || new_pc_o !== 32'h1234_5678) begin
         miscompares++;
         $display("FAIL reset_hold_entry: got stall=%b pc=%h want 01111/12345678", stall_o, new_pc_o);
      end
      rst = 1'b1; stallreq_mem_i = 0;
      #1;
      model_reset();
      vectors++;
      if ({stall_o, flush_o, new_pc_valid_o, new_pc_o, stall_cnt_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_async: got stall=%b flush=%b v=%b pc=%h cnt=%0d want all 0",
                  stall_o, flush_o, new_pc_valid_o, new_pc_o, stall_cnt_o);
      end
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 0, 32'h0);
         vectors++;
         if (new_pc_valid_o !== 1'b0 || flush_o !== 5'b0 || new_pc_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_no_redirect[%0d]: got v=%b flush=%b pc=%h want 0/0/0",
                     i, new_pc_valid_o, flush_o, new_pc_o);
         end
         tick();
      end
   endtask

   task automatic test_decode();
      for (int c = 0; c < 8; c++) begin
         apply(c[0], c[1], c[2], 0, 32'h0);
         vectors++;
         if (stall_o !== exp_stall || flush_o !== exp_flush) begin
            miscompares++;
            $display("FAIL decode[id%0d exe%0d mem%0d]: got %b/%b want %b/%b",
                     c[0], c[1], c[2], stall_o, flush_o, exp_stall, exp_flush);
         end
         tick();
      end
      apply(1, 1, 1, 0, 32'h0);
      vectors++;
      if (stall_o !== 5'b01111 || flush_o !== 5'b10000) begin
         miscompares++;
         $display("FAIL decode_all: got %b/%b want 01111/10000", stall_o, flush_o);
      end
      tick();
      apply(0, 1, 0, 0, 32'h0);
      vectors++;
      if (stall_o !== 5'b00111 || flush_o !== 5'b01000) begin
         miscompares++;
         $display("FAIL decode_exe: got %b/%b want 00111/01000", stall_o, flush_o);
      end
      tick();
   endtask

   task automatic test_redirect();
      apply(0, 0, 0, 1, 32'hBFC0_0380); tick();
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (flush_o !== 5'b11111 || stall_o !== 5'b0 || new_pc_valid_o !== 1'b1 ||
          new_pc_o !== 32'hBFC0_0380) begin
         miscompares++;
         $display("FAIL redirect_pulse: got flush=%b stall=%b v=%b pc=%h want 11111/00000/1/bfc00380",
                  flush_o, stall_o, new_pc_valid_o, new_pc_o);
      end
      tick();
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (new_pc_valid_o !== 1'b0 || flush_o !== 5'b0 || new_pc_o !== 32'hBFC0_0380) begin
         miscompares++;
         $display("FAIL redirect_one_cycle: got v=%b flush=%b pc=%h want 0/00000/bfc00380",
                  new_pc_valid_o, flush_o, new_pc_o);
      end
      tick();
   endtask

   task automatic test_held_flush();
      apply(0, 0, 1, 1, 32'hA000_0040);
      vectors++;
      if (stall_o !== 5'b01111 || new_pc_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL held_req_cycle: got stall=%b v=%b want 01111/0", stall_o, new_pc_valid_o);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 1, (i == 1), 32'h8000_0000);
         vectors++;
         if (stall_o !== 5'b01111 || new_pc_valid_o !== 1'b0 || flush_o !== 5'b10000) begin
            miscompares++;
            $display("FAIL held_wait[%0d]: got stall=%b flush=%b v=%b want 01111/10000/0",
                     i, stall_o, flush_o, new_pc_valid_o);
         end
         tick();
      end
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (new_pc_valid_o !== 1'b0 || stall_o !== 5'b0) begin
         miscompares++;
         $display("FAIL held_release: got v=%b stall=%b want 0/00000", new_pc_valid_o, stall_o);
      end
      tick();
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (new_pc_valid_o !== 1'b1 || flush_o !== 5'b11111 || new_pc_o !== 32'hA000_0040) begin
         miscompares++;
         $display("FAIL held_flush: got v=%b flush=%b pc=%h want 1/11111/a0000040",
                  new_pc_valid_o, flush_o, new_pc_o);
      end
      tick();
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (new_pc_valid_o !== 1'b0 || new_pc_o !== 32'hA000_0040) begin
         miscompares++;
         $display("FAIL held_after: got v=%b pc=%h want 0/a0000040", new_pc_valid_o, new_pc_o);
      end
      tick();
   endtask

   task automatic test_counter_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin apply(1, 0, 0, 0, 32'h0); tick(); end
      apply(0, 0, 0, 1, 32'h0000_1000);
      vectors++;
      if (stall_cnt_o !== 4'd1 || stall_cnt_o !== exp_cnt) begin
         miscompares++;
         $display("FAIL cnt_wrap: got %0d want 1 (model %0d)", stall_cnt_o, exp_cnt);
      end
      tick();
      apply(1, 1, 1, 0, 32'h0);  // FLUSH cycle: stall requests ignored
      vectors++;
      if (stall_o !== 5'b0 || new_pc_valid_o !== 1'b1) begin
         miscompares++;
         $display("FAIL cnt_flush_cycle: got stall=%b v=%b want 00000/1", stall_o, new_pc_valid_o);
      end
      tick();
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (stall_cnt_o !== 4'd1) begin
         miscompares++;
         $display("FAIL cnt_flush_uncounted: got %0d want 1", stall_cnt_o);
      end
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      for (int i = 0; i < 8; i++) begin apply(0, 0, 1, 0, 32'h0); tick(); end
      for (int i = 0; i < 3; i++) begin
         apply(0, 0, 0, 0, 32'h0);
         vectors++;
         if (wdt_timeout_o !== exp_wdt) begin
            miscompares++;
            $display("FAIL wdt_trip[%0d]: got %b want %b", i, wdt_timeout_o, exp_wdt);
         end
         tick();
      end
      do_reset();
      for (int i = 0; i < 15; i++) begin apply(0, (i != 7), 0, 0, 32'h0); tick(); end
      apply(0, 0, 0, 0, 32'h0);
      vectors++;
      if (wdt_timeout_o !== 1'b0 || wdt_timeout_o !== exp_wdt) begin
         miscompares++;
         $display("FAIL wdt_gap: got %b want 0", wdt_timeout_o);
      end
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom);
         vectors++;
         if (stall_o !== exp_stall || flush_o !== exp_flush || new_pc_valid_o !== exp_valid ||
             new_pc_o !== exp_pc || stall_cnt_o !== exp_cnt || wdt_timeout_o !== exp_wdt) begin
            miscompares++;
            $display("FAIL random[%0d]: got s=%b f=%b v=%b pc=%h c=%0d w=%b want s=%b f=%b v=%b pc=%h c=%0d w=%b",
                     i, stall_o, flush_o, new_pc_valid_o, new_pc_o, stall_cnt_o, wdt_timeout_o,
                     exp_stall, exp_flush, exp_valid, exp_pc, exp_cnt, exp_wdt);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_decode();
      test_redirect();
      test_held_flush();
      test_counter_wrap();
      test_watchdog();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
